// File: rtl/chan_scan_pkg.sv
// chan_scan_pkg: shared states, phase lengths and channel slice helper for the channel scanner
package chan_scan_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, LATCH, READOUT, DONE} state_t;
  localparam int CLR_CYCLES = 2;
  localparam int SETTLE_CYCLES = 2;
  function automatic int ch_off(input int ch, input int w);
    return ch * w;
  endfunction
endpackage

// File: rtl/scan_gate_timer.sv
// scan_gate_timer: loadable down-counter that stops at zero and flags it
module scan_gate_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] cnt;
  // load wins; otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign zero = (cnt == '0);
endmodule

// File: rtl/channel_scan_ctrl.sv
// channel_scan_ctrl: frame sequencer (clear, gate, settle, snapshot, stream); CHAN_SCAN_SAT_EN saturates overflowed words
module channel_scan_ctrl
  import chan_scan_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 12,
  parameter int GATE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    continuous,
  input  logic [GATE_W-1:0]       gate_len,
  input  logic [NUM_CH*CNT_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]       ch_ovf,
  output logic                    ch_clr,
  output logic                    ch_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2:0]              out_ch,
  output logic [CNT_W-1:0]        out_data,
  output logic                    out_ovf,
  output logic                    busy,
  output logic                    done
);
  state_t state, next;
  logic [GATE_W-1:0] gate_q, gate_eff, load_val;
  logic load, zero, last, frame_start;
  logic [2:0] idx;
  logic [CNT_W-1:0] snap [8];
  logic [7:0] snap_ovf;
  logic [CNT_W-1:0] word;
  scan_gate_timer #(.W(GATE_W)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(load), .value(load_val), .zero(zero)
  );
  assign gate_eff = (gate_len == '0) ? GATE_W'(1) : gate_len;
  assign last = out_ready && idx == 3'(NUM_CH - 1);
  assign frame_start = (state == IDLE && start) || (state == DONE && continuous);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  // next state and phase timer loads
  always_comb begin
    next = state;
    load = 1'b0;
    load_val = '0;
    case (state)
      IDLE:    if (start) begin next = CLEAR; load = 1'b1; load_val = GATE_W'(CLR_CYCLES - 1); end
      CLEAR:   if (zero) begin next = GATE; load = 1'b1; load_val = gate_q - GATE_W'(1); end
      GATE:    if (zero) begin next = SETTLE; load = 1'b1; load_val = GATE_W'(SETTLE_CYCLES - 1); end
      SETTLE:  if (zero) next = LATCH;
      LATCH:   next = READOUT;
      READOUT: if (last) next = DONE;
      DONE:    if (continuous) begin next = CLEAR; load = 1'b1; load_val = GATE_W'(CLR_CYCLES - 1); end
               else next = IDLE;
      default: next = IDLE;
    endcase
  end
  // gate length, snapshot bank and readout index
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gate_q <= GATE_W'(1);
      idx <= '0;
      snap_ovf <= '0;
      for (int i = 0; i < 8; i++) snap[i] <= '0;
    end else begin
      if (frame_start) gate_q <= gate_eff;
      if (state == LATCH) begin
        idx <= '0;
        for (int i = 0; i < NUM_CH; i++) begin
          snap[i] <= ch_data[ch_off(i, CNT_W) +: CNT_W];
          snap_ovf[i] <= ch_ovf[i];
        end
      end else if (state == READOUT && out_ready) idx <= idx + 3'd1;
    end
`ifdef CHAN_SCAN_SAT_EN
  assign word = snap_ovf[idx] ? '1 : snap[idx];
`else
  assign word = snap[idx];
`endif
  assign ch_clr = (state == IDLE) || (state == CLEAR);
  assign ch_en = (state == GATE);
  assign out_valid = (state == READOUT);
  assign out_ch = out_valid ? idx : 3'd0;
  assign out_data = out_valid ? word : '0;
  assign out_ovf = out_valid && snap_ovf[idx];
  assign busy = (state != IDLE);
  assign done = (state == DONE);
endmodule

// File: tb/tb_channel_scan_ctrl.sv
// tb_channel_scan_ctrl: table-driven frame check plus backpressure, overflow, continuous and reset sequences
module tb_channel_scan_ctrl;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 12;
  localparam int GATE_W = 16;
`ifdef CHAN_SCAN_SAT_EN
  localparam logic [11:0] OVF_WORD = 12'd4095;
`else
  localparam logic [11:0] OVF_WORD = 12'd3;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, continuous = 1'b0, out_ready = 1'b0;
  logic [GATE_W-1:0] gate_len = '0;
  logic [NUM_CH*CNT_W-1:0] ch_data = '0;
  logic [NUM_CH-1:0] ch_ovf = '0;
  logic ch_clr, ch_en, out_valid, out_ovf, busy, done;
  logic [2:0] out_ch;
  logic [CNT_W-1:0] out_data;
  channel_scan_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .GATE_W(GATE_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .gate_len(gate_len),
    .ch_data(ch_data), .ch_ovf(ch_ovf), .ch_clr(ch_clr), .ch_en(ch_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data), .out_ovf(out_ovf),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        start;
    logic        ready;
    logic [20:0] exp;
  } vec_t;
  vec_t vecs[$];
  int checks = 0, errors = 0;
  int en_cyc, nwords, ndone;
  logic [2:0] wch [8];
  logic [11:0] wd [8];
  logic wo [8];
  function automatic logic [20:0] pk(input logic clr, en, v, input logic [2:0] ch,
                                     input logic [11:0] d, input logic ov, b, dn);
    return {clr, en, v, ch, d, ov, b, dn};
  endfunction
  function automatic logic [20:0] obs();
    return {ch_clr, ch_en, out_valid, out_ch, out_data, out_ovf, busy, done};
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic collect();
    int c;
    en_cyc = 0; nwords = 0; ndone = 0;
    for (c = 0; c < 300; c++) begin
      if (ch_en) en_cyc++;
      if (out_valid && nwords < 8) begin
        wch[nwords] = out_ch; wd[nwords] = out_data; wo[nwords] = out_ovf;
        nwords++;
      end
      if (done) begin
        ndone++;
        break;
      end
      step();
    end
    chk("frame_done", ndone, 1);
  endtask
  task automatic run_frame(input logic [GATE_W-1:0] g);
    gate_len = g; out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    collect();
  endtask
  task automatic wait_valid();
    int c;
    for (c = 0; c < 100 && !out_valid; c++) step();
    chk("wait_valid", out_valid, 1);
  endtask
  initial begin
    vecs.push_back('{1'b1, 1'b1, pk(1, 0, 0, 0, 0, 0, 1, 0)});
    vecs.push_back('{1'b0, 1'b1, pk(1, 0, 0, 0, 0, 0, 1, 0)});
    for (int i = 0; i < 10; i++) vecs.push_back('{1'b0, 1'b1, pk(0, 1, 0, 0, 0, 0, 1, 0)});
    for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 1'b1, pk(0, 0, 0, 0, 0, 0, 1, 0)});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{1'b0, 1'b1, pk(0, 0, 1, 3'(i), 12'(10 * (i + 1)), 0, 1, 0)});
    vecs.push_back('{1'b0, 1'b1, pk(0, 0, 0, 0, 0, 0, 1, 1)});
    vecs.push_back('{1'b0, 1'b1, pk(1, 0, 0, 0, 0, 0, 0, 0)});
    // reset
    #12;
    chk("reset_outputs", obs(), pk(1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk) rst_n = 1'b1;
    step(); step();
    chk("idle_no_start", obs(), pk(1, 0, 0, 0, 0, 0, 0, 0));
    // single frame, gate 10
    gate_len = 16'd10;
    ch_data = {12'd40, 12'd30, 12'd20, 12'd10};
    foreach (vecs[i]) begin
      start = vecs[i].start; out_ready = vecs[i].ready;
      step();
      chk($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end
    // backpressure on ch1, snapshot immune to counter changes
    gate_len = 16'd3; out_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    wait_valid();
    chk("bp_ch0", {out_ch, out_data}, {3'd0, 12'd10});
    ch_data = {4{12'd99}};
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_ch1_first", {out_valid, out_ch, out_data}, {1'b1, 3'd1, 12'd20});
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_hold%0d", i), {out_valid, out_ch, out_data}, {1'b1, 3'd1, 12'd20});
    end
    out_ready = 1'b1;
    step();
    chk("bp_ch2", {out_valid, out_ch, out_data}, {1'b1, 3'd2, 12'd30});
    step();
    chk("bp_ch3", {out_valid, out_ch, out_data}, {1'b1, 3'd3, 12'd40});
    step();
    chk("bp_done", {out_valid, done}, 2'b01);
    step();
    chk("bp_idle", {busy, done}, 2'b00);
    // overflow on ch2
    ch_data = {12'd40, 12'd3, 12'd20, 12'd10};
    ch_ovf = 4'b0100;
    run_frame(16'd4);
    chk("ovf_nwords", nwords, 4);
    chk("ovf_ch2", {wch[2], wd[2], wo[2]}, {3'd2, OVF_WORD, 1'b1});
    chk("ovf_ch1", {wd[1], wo[1]}, {12'd20, 1'b0});
    chk("ovf_ch3", {wd[3], wo[3]}, {12'd40, 1'b0});
    ch_ovf = '0;
    step();
    // gate_len 0 behaves as 1
    run_frame(16'd0);
    chk("gate0_en", en_cyc, 1);
    step();
    run_frame(16'd5);
    chk("gate5_en", en_cyc, 5);
    step();
    // continuous restart then stop
    continuous = 1'b1;
    run_frame(16'd2);
    step();
    chk("cont_restart", {ch_clr, ch_en, busy, done}, 4'b1010);
    continuous = 1'b0;
    collect();
    chk("cont_words", nwords, 4);
    chk("cont_en", en_cyc, 2);
    step();
    chk("cont_stop", busy, 0);
    // reset in the middle of readout
    ch_data = {12'd40, 12'd30, 12'd20, 12'd10};
    gate_len = 16'd2; out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    wait_valid();
    step(); step();
    chk("rst_mid_ch2", out_ch, 2);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_outputs", obs(), pk(1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_no_done%0d", i), {busy, done}, 2'b00);
    end
    run_frame(16'd2);
    chk("rst_new_frame", {nwords[3:0], wch[0], wd[0], wch[3], wd[3]}, {4'd4, 3'd0, 12'd10, 3'd3, 12'd40});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/channel_scan_ctrl.md
Name: channel_scan_ctrl

Overview:
- Sequences a bank of NUM_CH impulse counters through repeated measurement frames.
- Each frame runs: clear counters -> open gate for a programmed number of clk cycles -> settle -> snapshot all counts -> stream counts one channel at a time over a valid/ready port.
- Sits between the asynchronous impulse counters and the readout/IO logic. It owns the counter clear and gate-enable signals.

Parameters:
- NUM_CH, 4, number of counter channels (2..8)
- CNT_W, 12, width of each counter value
- GATE_W, 16, width of the gate-length register

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a frame; level-sampled in IDLE
- continuous  in  1  when 1 at frame end, start the next frame immediately
- gate_len  in  GATE_W  gate window in clk cycles; latched at frame start
- ch_data  in  NUM_CH*CNT_W  counter values; channel i at bits [i*CNT_W +: CNT_W]
- ch_ovf  in  NUM_CH  counter overflow flags
- ch_clr  out  1  active-high clear to all counters
- ch_en  out  1  gate enable; impulses are counted only while 1
- out_valid  out  1  readout word available
- out_ready  in  1  downstream accepts word
- out_ch  out  3  channel index of current word
- out_data  out  CNT_W  count of current word
- out_ovf  out  1  overflow flag of current word
- busy  out  1  1 in every state except IDLE
- done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (async assert, sync release): state=IDLE; ch_clr=1, ch_en=0, out_valid=0, out_ch=0, out_data=0, out_ovf=0, busy=0, done=0; all snapshot registers cleared.
- ch_clr is also 1 throughout IDLE, so the counters are held cleared while idle.
- IDLE: if start=1, latch gate_len (a value of 0 is treated as 1) and go to CLEAR next cycle.
- CLEAR: ch_clr=1 for CLR_CYCLES=2 cycles, then GATE.
- GATE: ch_clr=0, ch_en=1 for exactly the latched gate_len cycles, then SETTLE.
- SETTLE: ch_en=0 for SETTLE_CYCLES=2 cycles, letting the ripple/async counters stabilise before sampling.
- LATCH: 1 cycle; snapshot all ch_data and ch_ovf; channel index idx=0.
- READOUT:
  - out_valid=1, driving out_ch=idx, out_data=snap[idx], out_ovf=snap_ovf[idx].
  - A word transfers on a cycle with out_valid&out_ready; idx then increments.
  - Outputs stay stable while out_valid=1 and out_ready=0.
  - Back-to-back transfers are allowed: one word per cycle while out_ready=1.
  - The transfer of idx=NUM_CH-1 ends the frame: next cycle done=1 and out_valid=0.
- After the done cycle: go to CLEAR if continuous=1, otherwise IDLE. continuous is sampled only at that point.
- start is ignored while busy. Changes to gate_len mid-frame have no effect until the next frame start.
- Snapshots are not updated during READOUT; counter changes after LATCH are invisible until the next frame.
- out_ch is zero-extended from idx.
- Gate timing: with gate_len=G, ch_en is high for G cycles. Minimum frame length to first out_valid = 2+G+2+1 cycles after leaving IDLE.
- rst_n asserted mid-frame: immediate return to reset values. A partial readout is abandoned and no done pulse is produced.

Optional Feature:
- Macro CHAN_SCAN_SAT_EN.
- Defined: when snap_ovf[idx]=1, out_data is forced to all ones (4095 for CNT_W=12); out_ovf is still reported.
- Undefined: out_data is the raw wrapped count.

Decomposition:
- Package chan_scan_pkg holds:
  - state enum: IDLE, CLEAR, GATE, SETTLE, LATCH, READOUT, DONE
  - constants CLR_CYCLES=2 and SETTLE_CYCLES=2
  - a helper for the channel-slice offset
- One natural sub-module: scan_gate_timer, a loadable down-counter with a zero flag, used for the CLEAR, GATE and SETTLE durations.

Test Plan:
- Reset check: hold rst_n=0 -> ch_clr=1, ch_en=0, out_valid=0, busy=0; release with start=0 -> remains IDLE.
- Single frame, gate_len=10, ch_data={40,30,20,10}, out_ready=1:
  - ch_clr high 2 cycles, then ch_en high exactly 10 cycles.
  - Words out in order ch0=10, ch1=20, ch2=30, ch3=40, one per cycle.
  - done pulses once, then IDLE.
- Backpressure: out_ready=0 for 5 cycles on ch1 -> out_ch=1 and out_data held stable; no word skipped or duplicated.
- Overflow: ch_ovf[2]=1 with ch_data ch2=3 -> out_ovf=1 for ch2, out_data=3 (4095 with CHAN_SCAN_SAT_EN).
- Boundary cases:
  - gate_len=0 -> ch_en high 1 cycle.
  - continuous=1 -> DONE goes directly to CLEAR; drop continuous -> IDLE after the current frame.
- Reset mid-READOUT (after ch1 accepted) -> outputs return to reset values immediately, no done pulse; a new start gives a full frame from ch0.
